// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the DAC end of the effects chain: one-sample hold buffer,
// BCLK/LRCLK generation from clk, 32-bit stereo frames carrying the same sample on both slots.
module i2s_dac_tx #(
  parameter int unsigned clk_div      = 4,
  parameter int unsigned sample_width = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [sample_width-1:0] sample_in,
  input  logic                    flag_clr,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    sample_req,
  output logic                    overrun,
  output logic                    underrun
);

  localparam int unsigned DivW   = $clog2(clk_div);
  localparam int unsigned FrameW = 2 * sample_width;
  localparam logic [DivW-1:0] DivLast = DivW'(clk_div - 1);

  logic [DivW-1:0]         div_cnt_q, div_cnt_d;
  logic                    bclk_q, bclk_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic [FrameW-2:0]       shift_q, shift_d;
  logic [sample_width-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    sample_req_q, sample_req_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;

  logic       term;
  logic       fall;
  logic       load;
  logic [4:0] bit_cnt_inc;

  always_comb begin
    term        = (div_cnt_q == DivLast);
    fall        = term & bclk_q;
    bit_cnt_inc = bit_cnt_q + 5'd1;
    load        = fall & (bit_cnt_inc == 5'd1);
  end

  // Divider, bit counter and word select.
  always_comb begin
    div_cnt_d = term ? '0 : div_cnt_q + DivW'(1);
    bclk_d    = term ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    if (fall) begin
      bit_cnt_d = bit_cnt_inc;
      lrclk_d   = bit_cnt_inc[4];
    end
  end

  // Serializer: load drives the frame MSB directly, the rest shifts out on later falls.
  always_comb begin
    sdata_d = sdata_q;
    shift_d = shift_q;
    if (load) begin
      sdata_d = hold_q[sample_width-1];
      shift_d = {hold_q[sample_width-2:0], hold_q};
    end else if (fall) begin
      sdata_d = shift_q[FrameW-2];
      shift_d = {shift_q[FrameW-3:0], 1'b0};
    end
  end

  // Hold buffer and sticky flags; a set event beats flag_clr.
  always_comb begin
    hold_d      = valid ? sample_in : hold_q;
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (valid) begin
      hold_full_d = 1'b1;
    end
    sample_req_d = load;
    overrun_d    = (valid & hold_full_q & ~load) | (overrun_q & ~flag_clr);
    underrun_d   = (load & ~hold_full_q) | (underrun_q & ~flag_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      sample_req_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      sample_req_q <= sample_req_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    bclk       = bclk_q;
    lrclk      = lrclk_q;
    sdata      = sdata_q;
    sample_req = sample_req_q;
    overrun    = overrun_q;
    underrun   = underrun_q;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Serial DAC transmitter at the output end of the effects chain. Accepts processed 16-bit samples with a single-cycle `valid` strobe and holds one sample in a buffer. Serializes each sample as an I2S frame (same sample on left and right, MSB first, one-bit delay after LRCLK edge), generating BCLK and LRCLK from the system clock. Issues a per-frame sample request toward the pipeline and reports overrun and underrun with sticky flags.

## Interface
- `clk_div`, default 4: BCLK half-period in `clk` cycles; legal range is 2 or more.
- `sample_width`, default 16: bits per channel slot; fixed at 16 in this design.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `valid` in 1: one-cycle strobe that qualifies `sample_in`.
- `sample_in` in 16: signed two's-complement sample.
- `flag_clr` in 1: clears `overrun` and `underrun`.
- `bclk` out 1: bit clock, registered.
- `lrclk` out 1: word select, registered; 0 = left slot, 1 = right slot.
- `sdata` out 1: serial data, registered; changes only on BCLK falling edges.
- `sample_req` out 1: one-cycle pulse when the frame buffer is loaded.
- `overrun` out 1: sticky flag; a buffered sample was overwritten before it was sent.
- `underrun` out 1: sticky flag; a frame started with no new sample.

## Operation
- **Divider.** `div_cnt` counts 0..`clk_div`-1. At terminal count, `bclk` toggles and `div_cnt` returns to 0.
  - rise = terminal count while `bclk`=0.
  - fall = terminal count while `bclk`=1.
- **Bit counter.** `bit_cnt` is 5 bits. It increments modulo 32 on every fall.
  - On the same fall, `lrclk` is set to bit 4 of the new `bit_cnt`.
  - Slots are therefore 0–15 left and 16–31 right.
- **Hold buffer.** Consists of `hold` (16 bits) and `hold_full`.
  - `valid` writes `sample_in` into `hold` and sets `hold_full`.
  - If `hold_full` was already 1 and no load happens in the same cycle, set `overrun`.
- **Load.** Occurs on the fall where the new `bit_cnt` is 1.
  - Build frame = {`hold`, `hold`}. Drive `sdata` with frame[31] and set the shift register to frame[30:0].
  - Pulse `sample_req` for that one cycle.
  - If `hold_full`=1, clear it. If it was 0, set `underrun`; the stale `hold` value is replayed.
- **Shift.** On every other fall, `sdata` takes the shift register MSB and the register shifts left by one.
  - Bit 0 of the frame (right LSB) is therefore sent while `bit_cnt`=0 of the next frame. This is the standard I2S one-bit delay.
- **Simultaneous `valid` and load.**
  - The load uses the old `hold` contents.
  - The new sample is written to `hold`, and `hold_full` ends at 1.
  - Neither `overrun` nor `underrun` is set when `hold_full` was 1 before the cycle.
  - If `hold_full` was 0 before the cycle, `underrun` is set, because the load consumes nothing new.
- **Flag clear.** `flag_clr` clears both flags. A set event in the same cycle wins, so the flag stays 1.
- **No handshake back-pressure.** `sample_req` is advisory. Upstream samples at the frame rate of 1/(64·`clk_div`) `clk`.

## Timing
- **Reset values.** `rst`=1 on a clock edge sets the following, and holds them while `rst`=1:
  - `bclk`=0, `lrclk`=0, `sdata`=0, `sample_req`=0, `overrun`=0, `underrun`=0.
  - `div_cnt`=0, `bit_cnt`=0, `hold`=0, `hold_full`=0, shift register=0.
- **First edges after `rst` deasserts.**
  - First rise: after `clk_div` cycles.
  - First fall, which is also the first load: after 2·`clk_div` cycles.
- **Periods.** BCLK period is 2·`clk_div` cycles. A frame is 32 BCLK periods, i.e. 64·`clk_div` cycles. Loads repeat every 64·`clk_div` cycles.
- **Edge alignment.** `lrclk` and `sdata` change in the same cycle as the falling edge of `bclk`, never on a rise.
- **Latency.** From `valid` to the MSB appearing on `sdata` is at most one frame plus the time to the next load, and is never zero.
- **Reset mid-frame.** Everything returns to reset values at once. No partial frame is completed. The sequence restarts as after power-up.

## Test plan
- **Single sample.** `clk_div`=2, `rst` released, `valid` with 16'hA5C3 before the first load. Required:
  - `sample_req` at cycle 4.
  - `sdata` sequence from that fall: A5C3 MSB-first in the left slot, then A5C3 in the right slot, with the right LSB during the next frame's `bit_cnt`=0.
  - `lrclk` high for falls 16..31.
  - `underrun`=0.
- **Underrun.** No `valid` after reset. Required:
  - First load sends 0x0000 and sets `underrun`.
  - Then `valid` with 0x7FFF: the next frame sends 0x7FFF on both slots.
  - With no further `valid`, the frame after that replays 0x7FFF and `underrun` stays 1.
- **Overrun.** Two `valid` strobes (0x1111, then 0x2222) within one frame. Required:
  - `overrun`=1 after the second strobe.
  - The next frame sends 0x2222.
- **Simultaneous events.** `valid` with 0x3333 in the exact load cycle while `hold`=0x4444 and `hold_full`=1. Required:
  - The frame sends 0x4444 and the next frame sends 0x3333.
  - No flag is set.
- **Flag clear.** `flag_clr` pulsed. Required:
  - Both flags go to 0.
  - If `flag_clr` coincides with an overrun event, `overrun` stays 1.
- **Mid-frame reset.** `rst` pulsed for one cycle at `bit_cnt`=20. Required:
  - All outputs and internal counters return to their reset values on that edge.
  - The next load occurs 2·`clk_div` cycles after `rst` deasserts.
